// File: rtl/ama_riscv_dmem_ctrl_if.sv
// Bus bundle for the DMEM access controller: core request, memory port and response.
// The slave modport is the controller's view; master is the core/memory side.
interface ama_riscv_dmem_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [2:0]        req_width;
    logic [31:0]       req_wdata;
    logic [3:0]        store_mask;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt;
    logic [31:0]       mem_rdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport slave (
        input  req_valid, req_we, req_addr, req_width, req_wdata, store_mask,
        input  mem_gnt, mem_rdata,
        output req_ready, mem_en, mem_we, mem_addr, mem_wdata,
        output rsp_valid, rsp_rdata, rsp_err
    );

    modport master (
        output req_valid, req_we, req_addr, req_width, req_wdata, store_mask,
        output mem_gnt, mem_rdata,
        input  req_ready, mem_en, mem_we, mem_addr, mem_wdata,
        input  rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/ama_riscv_dmem_ctrl.sv
// DMEM access controller: issues stores/loads to a synchronous data memory through a
// small IDLE/ISSUE/RDATA FSM, aligns load data and rejects misaligned/illegal accesses.
module ama_riscv_dmem_ctrl #(
    parameter int ADDR_W = 14
) (
    input  logic                   clk,
    input  logic                   rst,
    ama_riscv_dmem_ctrl_if.slave   bus
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RDATA = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Loads must stay inside one word: half at offset 3 or word off offset 0 are rejected.
    function automatic logic load_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = (off == 2'd3);
            SZ_WORD: bad = (off != 2'd0);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [31:0] store_align(input logic [31:0] wdata,
                                                input logic [1:0]  size,
                                                input logic [1:0]  off);
        logic [31:0] res;
        case (size)
            SZ_WORD: res = wdata;
            default: res = wdata << {off, 3'b000};
        endcase
        return res;
    endfunction

    // width[2] selects zero-extension; words bypass the lane shift entirely.
    function automatic logic [31:0] load_extend(input logic [31:0] rdata,
                                                input logic [2:0]  width,
                                                input logic [1:0]  off);
        logic [31:0] sh;
        logic        sign;
        logic [31:0] res;
        sh = rdata >> {off, 3'b000};
        case (width[1:0])
            SZ_BYTE: begin
                sign = sh[7] & ~width[2];
                res  = {{24{sign}}, sh[7:0]};
            end
            SZ_HALF: begin
                sign = sh[15] & ~width[2];
                res  = {{16{sign}}, sh[15:0]};
            end
            SZ_WORD: begin
                sign = 1'b0;
                res  = rdata;
            end
            default: begin
                sign = 1'b0;
                res  = 32'h0000_0000;
            end
        endcase
        return res;
    endfunction

    logic [1:0]        state_q,     state_d;
    logic              cap_we_q,    cap_we_d;
    logic [2:0]        cap_width_q, cap_width_d;
    logic [1:0]        cap_off_q,   cap_off_d;
    logic              mem_en_q,    mem_en_d;
    logic [3:0]        mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q,   rsp_err_d;

    logic              req_ready_s;
    logic              accept_s;
    logic [1:0]        req_off_s;
    logic [1:0]        req_size_s;
    logic              req_err_s;
    logic              unused_addr_s;

    assign req_off_s   = bus.req_addr[1:0];
    assign req_size_s  = bus.req_width[1:0];
    assign req_ready_s = (state_q == IDLE) && !rst;
    assign accept_s    = bus.req_valid && req_ready_s;

    // Address bits beyond the memory's reach alias silently.
    assign unused_addr_s = ^bus.req_addr[31:ADDR_W+2];

    // Error classification of the request presented this cycle.
    always_comb begin
        req_err_s = 1'b0;
        if (req_size_s == 2'd3) begin
            req_err_s = 1'b1;
        end else if (bus.req_we) begin
            req_err_s = (bus.store_mask == 4'b0000);
        end else begin
            req_err_s = load_misaligned(req_size_s, req_off_s);
        end
    end

    // Next-state and output-register logic of the access FSM.
    always_comb begin
        state_d     = state_q;
        cap_we_d    = cap_we_q;
        cap_width_d = cap_width_q;
        cap_off_d   = cap_off_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    cap_we_d    = bus.req_we;
                    cap_width_d = bus.req_width;
                    cap_off_d   = req_off_s;
                    if (req_err_s) begin
                        // Rejected accesses answer immediately and never reach memory.
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d     = ISSUE;
                        mem_en_d    = 1'b1;
                        mem_we_d    = bus.req_we ? bus.store_mask : 4'b0000;
                        mem_addr_d  = bus.req_addr[ADDR_W+1:2];
                        mem_wdata_d = store_align(bus.req_wdata, req_size_s, req_off_s);
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                if (bus.mem_gnt) begin
                    mem_en_d = 1'b0;
                    mem_we_d = 4'b0000;
                    if (cap_we_q) begin
                        state_d     = IDLE;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = RDATA;
                    end
                end else begin
                    state_d = ISSUE;
                end
            end
            RDATA: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = load_extend(bus.mem_rdata, cap_width_q, cap_off_q);
            end
            default: begin
                state_d  = IDLE;
                mem_en_d = 1'b0;
                mem_we_d = 4'b0000;
            end
        endcase
    end

    // State and output registers; reset drops any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cap_we_q    <= 1'b0;
            cap_width_q <= 3'b000;
            cap_off_q   <= 2'b00;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 4'b0000;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'h0000_0000;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_we_q    <= cap_we_d;
            cap_width_q <= cap_width_d;
            cap_off_q   <= cap_off_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule
